// File: rtl/cpu_pkg.sv
// Shared constants for the fetch front end: reset/NOP encodings, PC step and FSM states.
package cpu_pkg;
    localparam logic [31:0] CPU_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] CPU_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC        = 32'd4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX; clear has priority over increment.
module sat_counter #(
    parameter int           W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != MAX))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/if_stage_control.sv
// Fetch-stage control: PC register, IF/ID register, stall/flush counters and stall watchdog.
module if_stage_control
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
    parameter logic [31:0] NOP_INSTR  = CPU_NOP_INSTR,
    parameter int          CNT_W      = 16,
    parameter int          WDOG_LIMIT = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PCWrite,
    input  logic             IFIDWrite,
    input  logic             IF_Flush,
    input  logic             PCSRC,
    input  logic [31:0]      BranchTarget,
    input  logic [31:0]      IM_Instruction,
    output logic [31:0]      IM_Address,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             StallTimeout,
    output logic [1:0]       State
);
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [31:0] instr_q, instr_d, pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        timeout_q;
    state_e      state_q;
    logic        redirect, stall;
    logic [WD_W-1:0] wdog_cnt;

    // A redirect cycle is never a stall cycle, even when the hold inputs are low.
    assign redirect = PCSRC | IF_Flush;
    assign stall    = ~redirect & ~(PCWrite & IFIDWrite);
    assign pc_plus4 = pc_q + PC_INC;

    always_comb begin
        pc_d = pc_q;
        if (PCSRC)
            pc_d = BranchTarget;
        else if (PCWrite)
            pc_d = pc_plus4;

        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        if (redirect) begin
            instr_d = NOP_INSTR;
            pcp4_d  = '0;
            valid_d = 1'b0;
        end else if (IFIDWrite) begin
            instr_d = IM_Instruction;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    // Timeout fires on the edge that completes the WDOG_LIMIT-th consecutive stall cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_RUN;
            timeout_q <= 1'b0;
        end else begin
            if (redirect)
                state_q <= ST_REDIRECT;
            else if (stall)
                state_q <= ST_STALL;
            else
                state_q <= ST_RUN;
            if (stall && (wdog_cnt == WD_W'(WDOG_LIMIT - 1)))
                timeout_q <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i(Clk), .rst_i(Reset), .clr_i(1'b0), .inc_i(stall), .cnt_o(StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i(Clk), .rst_i(Reset), .clr_i(1'b0), .inc_i(redirect), .cnt_o(FlushCount)
    );

    sat_counter #(.W(WD_W), .MAX(WD_W'(WDOG_LIMIT))) u_wdog_cnt (
        .clk_i(Clk), .rst_i(Reset), .clr_i(~stall), .inc_i(stall), .cnt_o(wdog_cnt)
    );

    assign IM_Address       = pc_q;
    assign IFID_Instruction = instr_q;
    assign IFID_PCPlus4     = pcp4_q;
    assign IFID_Valid       = valid_q;
    assign StallTimeout     = timeout_q;
    assign State            = state_q;
endmodule

// File: tb/tb_if_stage_control.sv
// Bench for if_stage_control: cycle-level reference model plus directed literal checks.
module tb_if_stage_control;
    logic        Clk = 1'b0;
    logic        Reset, Reset2;
    logic        PCWrite, IFIDWrite, IF_Flush, PCSRC;
    logic [31:0] BranchTarget;
    logic [31:0] IM_Instruction, IM_Address, IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid, StallTimeout;
    logic [15:0] StallCount, FlushCount;
    logic [1:0]  State;

    logic [31:0] im2, addr2, instr2, pcp4_2;
    logic        valid2, to2;
    logic [3:0]  sc2, fc2;
    logic [1:0]  st2;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    assign IM_Instruction = pat(IM_Address);
    assign im2            = pat(addr2);

    if_stage_control dut (
        .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IF_Flush(IF_Flush), .PCSRC(PCSRC), .BranchTarget(BranchTarget),
        .IM_Instruction(IM_Instruction), .IM_Address(IM_Address),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .StallCount(StallCount), .FlushCount(FlushCount),
        .StallTimeout(StallTimeout), .State(State)
    );

    if_stage_control #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(4)) dut2 (
        .Clk(Clk), .Reset(Reset2), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IF_Flush(IF_Flush), .PCSRC(PCSRC), .BranchTarget(BranchTarget),
        .IM_Instruction(im2), .IM_Address(addr2),
        .IFID_Instruction(instr2), .IFID_PCPlus4(pcp4_2),
        .IFID_Valid(valid2), .StallCount(sc2), .FlushCount(fc2),
        .StallTimeout(to2), .State(st2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: state of the fetch front end as the rules describe it.
    logic [31:0] m_pc, m_instr, m_pcp4;
    logic        m_valid, m_to, m_ok = 1'b0;
    logic [15:0] m_stall, m_flush;
    logic [1:0]  m_state;
    int          m_run;

    always @(posedge Clk) begin
        if (Reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
            m_stall = 16'h0; m_flush = 16'h0; m_to = 1'b0; m_run = 0;
            m_state = 2'd0; m_ok = 1'b1;
        end else if (m_ok) begin
            automatic bit fl = PCSRC || IF_Flush;
            automatic bit hold = !fl && !(PCWrite && IFIDWrite);
            if (fl) begin
                m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
            end else if (IFIDWrite) begin
                m_instr = pat(m_pc); m_pcp4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (PCSRC) m_pc = BranchTarget;
            else if (PCWrite) m_pc = m_pc + 32'd4;
            if (fl && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
            if (hold && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
            if (hold) begin
                if (m_run < 8) m_run = m_run + 1;
                if (m_run >= 8) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
            m_state = fl ? 2'd2 : (hold ? 2'd1 : 2'd0);
        end
    end

    always @(negedge Clk) begin
        if (m_ok) begin
            chk("pc", IM_Address, m_pc);
            chk("ifid_instr", IFID_Instruction, m_instr);
            chk("ifid_pcp4", IFID_PCPlus4, m_pcp4);
            chk("ifid_valid", {31'b0, IFID_Valid}, {31'b0, m_valid});
            chk("stall_cnt", {16'b0, StallCount}, {16'b0, m_stall});
            chk("flush_cnt", {16'b0, FlushCount}, {16'b0, m_flush});
            chk("timeout", {31'b0, StallTimeout}, {31'b0, m_to});
            chk("state", {30'b0, State}, {30'b0, m_state});
        end
    end

    task automatic cyc(input logic pw, input logic iw, input logic fl,
                       input logic src, input logic [31:0] tgt);
        PCWrite = pw; IFIDWrite = iw; IF_Flush = fl; PCSRC = src; BranchTarget = tgt;
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Reset = 1'b1; Reset2 = 1'b1;
        PCWrite = 1'b1; IFIDWrite = 1'b1; IF_Flush = 1'b0; PCSRC = 1'b0;
        BranchTarget = 32'h0;
        @(posedge Clk); #2;
        cyc(1, 1, 0, 1, 32'h100);
        chk("rst_pc", IM_Address, 32'h0);
        chk("rst_instr", IFID_Instruction, 32'h0);
        chk("rst_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("rst_state", {30'b0, State}, 32'h0);
        Reset = 1'b0;

        cyc(1, 1, 0, 0, 0);
        chk("run_pc4", IM_Address, 32'h4);
        chk("run_instr0", IFID_Instruction, 32'hA500_0000);
        chk("run_pcp4", IFID_PCPlus4, 32'h4);
        chk("run_valid", {31'b0, IFID_Valid}, 32'h1);
        cyc(1, 1, 0, 0, 0);
        chk("run_pc8", IM_Address, 32'h8);

        cyc(0, 0, 0, 0, 0);
        chk("stall_pc", IM_Address, 32'h8);
        chk("stall_instr", IFID_Instruction, 32'hA500_0004);
        chk("stall_cnt1", {16'b0, StallCount}, 32'h1);
        chk("stall_state", {30'b0, State}, 32'h1);
        cyc(1, 1, 0, 0, 0);
        chk("resume_instr", IFID_Instruction, 32'hA500_0008);
        chk("resume_state", {30'b0, State}, 32'h0);
        cyc(1, 1, 0, 0, 0);

        cyc(1, 1, 0, 1, 32'h40);
        chk("br_pc", IM_Address, 32'h40);
        chk("br_instr", IFID_Instruction, 32'h0);
        chk("br_valid", {31'b0, IFID_Valid}, 32'h0);
        chk("br_flush1", {16'b0, FlushCount}, 32'h1);
        chk("br_state", {30'b0, State}, 32'h2);
        cyc(1, 1, 0, 0, 0);
        chk("br_after_state", {30'b0, State}, 32'h0);
        chk("br_after_instr", IFID_Instruction, 32'hA500_0040);

        cyc(0, 0, 0, 1, 32'h80);
        chk("conf_pc", IM_Address, 32'h80);
        chk("conf_flush", {16'b0, FlushCount}, 32'h2);
        chk("conf_stall", {16'b0, StallCount}, 32'h1);
        cyc(1, 1, 0, 0, 0);

        cyc(1, 1, 1, 0, 0);
        chk("flush_pc", IM_Address, 32'h88);
        chk("flush_valid", {31'b0, IFID_Valid}, 32'h0);
        cyc(1, 0, 0, 0, 0);
        chk("mism_pc", IM_Address, 32'h8C);
        chk("mism_stall", {16'b0, StallCount}, 32'h2);
        cyc(1, 1, 0, 0, 0);

        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
        chk("wdog7", {31'b0, StallTimeout}, 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("wdog8", {31'b0, StallTimeout}, 32'h1);
        cyc(1, 1, 0, 0, 0);
        chk("wdog_sticky", {31'b0, StallTimeout}, 32'h1);
        Reset = 1'b1;
        cyc(1, 1, 0, 0, 0);
        chk("wdog_rst", {31'b0, StallTimeout}, 32'h0);
        chk("cnt_rst", {16'b0, FlushCount}, 32'h0);

        Reset = 1'b0; Reset2 = 1'b0;
        cyc(1, 1, 0, 0, 0);
        chk("wrap_pc", addr2, 32'h0);
        chk("wrap_pcp4", pcp4_2, 32'h0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
        chk("sat_stall", {28'b0, sc2}, 32'hF);
        chk("sat_flush", {28'b0, fc2}, 32'h0);
        cyc(1, 1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_stage_control.md
Name: if_stage_control

Overview:
Consumes the hazard unit's stall/flush/redirect outputs and applies them at the front of the 5-stage MIPS pipeline. Owns the PC register and the IF/ID pipeline register. Drives the instruction-memory fetch address. Also keeps stall/flush performance counters and a stall watchdog. Sits between instruction memory and ID; the hazard detector's PCWrite/IFIDWrite/IF_Flush and the branch unit's PCSRC terminate here.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, encoding written into IF/ID on flush (sll $0,$0,0)
CNT_W, 16, width of performance counters
WDOG_LIMIT, 8, consecutive stall cycles that trip StallTimeout

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
PCWrite  input  1  1 = PC may advance; 0 = hold PC
IFIDWrite  input  1  1 = IF/ID may load; 0 = hold IF/ID
IF_Flush  input  1  1 = replace instruction entering IF/ID with NOP_INSTR
PCSRC  input  1  branch taken; redirect PC to BranchTarget
BranchTarget  input  32  redirect address, word aligned
IM_Instruction  input  32  combinational instruction-memory read data for IM_Address
IM_Address  output  32  current PC
IFID_Instruction  output  32  registered instruction to ID
IFID_PCPlus4  output  32  registered PC+4 of that instruction
IFID_Valid  output  1  0 when IF/ID holds a reset or flush bubble
StallCount  output  CNT_W  saturating count of hold cycles
FlushCount  output  CNT_W  saturating count of flush/redirect cycles
StallTimeout  output  1  sticky; stall exceeded WDOG_LIMIT
State  output  2  FSM state, for debug

Behaviour:
- Clock: one clock, Clk. Reset is synchronous and active-high; all state changes on rising edge of Clk.
- Reset (wins over everything): PC=RESET_PC, IFID_Instruction=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, counters=0, StallTimeout=0, watchdog count=0, State=RUN.
- IM_Address = PC, combinational. Fetch latency: instruction at PC appears on IFID_Instruction 1 cycle later.
- PC update priority, per cycle:
  1. PCSRC=1: PC<=BranchTarget, regardless of PCWrite.
  2. PCWrite=1: PC<=PC+4, wrapping modulo 2^32.
  3. Otherwise PC holds.
- IF/ID update priority, per cycle:
  1. PCSRC=1 or IF_Flush=1: Instruction<=NOP_INSTR, PCPlus4<=0, Valid<=0, regardless of IFIDWrite.
  2. IFIDWrite=1: Instruction<=IM_Instruction, PCPlus4<=PC+4, Valid<=1.
  3. Otherwise all three fields hold.
- FSM states: RUN=0, STALL=1, REDIRECT=2.
  - From any state, PCSRC=1 or IF_Flush=1 -> REDIRECT.
  - Else PCWrite=0 or IFIDWrite=0 -> STALL.
  - Else -> RUN.
  - REDIRECT lasts exactly one cycle unless it is re-triggered.
- StallCount: +1 each cycle with (PCWrite=0 or IFIDWrite=0) and no PCSRC/IF_Flush. Saturates at all-ones.
- FlushCount: +1 each cycle with PCSRC=1 or IF_Flush=1. Saturates.
- Watchdog: counts consecutive STALL-condition cycles and clears on any non-stall cycle. Entering the WDOG_LIMIT-th consecutive cycle sets StallTimeout; it stays set until Reset. The counter saturates at WDOG_LIMIT.
- Mismatched PCWrite=1 with IFIDWrite=0 (no flush): PC advances while IF/ID holds. This is legal and is counted as a stall.
- PCSRC coincident with PCWrite=0 (stall conflict): redirect wins, and the cycle counts only in FlushCount.
- Inputs sampled during Reset are ignored; the first post-reset fetch is at RESET_PC.

Decomposition:
- Shared package (cpu_pkg): NOP_INSTR, RESET_PC defaults, FSM state encodings (RUN/STALL/REDIRECT), PC increment constant 4.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturating). Instantiate it twice for StallCount/FlushCount; the watchdog counter also fits it.

Test Plan:
- Reset then free-run with IM_Instruction=PC-derived pattern (all controls 1) -> IM_Address 0,4,8,12; IFID_Instruction lags by 1 cycle, IFID_PCPlus4=4,8,12; IFID_Valid=1 from cycle 2.
- Load-use stall: PCWrite=IFIDWrite=0 for 1 cycle at PC=8 -> PC holds 8, IF/ID holds the instruction from 4, StallCount=1, State=STALL, then RUN.
- Branch: PCSRC=1, BranchTarget=0x40 at PC=0x10 -> next PC=0x40, IFID_Instruction=0, Valid=0, FlushCount=1, State=REDIRECT for 1 cycle.
- Conflict: PCSRC=1 with PCWrite=0 -> PC=BranchTarget, FlushCount+1, StallCount unchanged.
- Watchdog: hold PCWrite=0 for 8 cycles (WDOG_LIMIT=8) -> StallTimeout=1 on the 8th; release, still 1; Reset -> 0.
- Wrap/saturation: RESET_PC=32'hFFFF_FFFC, run 1 cycle -> PC=0. With CNT_W=4, 20 stall cycles -> StallCount=15.
